// File: rtl/denorm_zero_if.sv
// Operand-unpack bus: raw exponent/fraction fields in, effective exponents,
// hidden bits and class flags out.
interface denorm_zero_if #(
   parameter int EXP_W = 8,
   parameter int SIG_W = 23
);
   logic             in_valid;
   logic [EXP_W-1:0] exp1;
   logic [SIG_W-1:0] sig1;
   logic [EXP_W-1:0] exp2;
   logic [SIG_W-1:0] sig2;

   logic             out_valid;
   logic [EXP_W-1:0] exp1_d;
   logic [EXP_W-1:0] exp2_d;
   logic [1:0]       n_concat;
   logic             zero1, denorm1, inf1, nan1;
   logic             zero2, denorm2, inf2, nan2;

   modport master (
      output in_valid, exp1, sig1, exp2, sig2,
      input  out_valid, exp1_d, exp2_d, n_concat,
      input  zero1, denorm1, inf1, nan1, zero2, denorm2, inf2, nan2
   );

   modport slave (
      input  in_valid, exp1, sig1, exp2, sig2,
      output out_valid, exp1_d, exp2_d, n_concat,
      output zero1, denorm1, inf1, nan1, zero2, denorm2, inf2, nan2
   );
endinterface

// File: rtl/denorm_zero.sv
// FP operand unpack: classifies each operand, forces subnormals to exponent 1
// with a cleared hidden bit, and registers everything with one cycle of latency.
module denorm_zero #(
   parameter int EXP_W = 8,
   parameter int SIG_W = 23
) (
   input  logic        clk,
   input  logic        reset,
   denorm_zero_if.slave bus
);
   // Index 0 is operand 1, index 1 is operand 2.
   logic [EXP_W-1:0] exp_in [2];
   logic [SIG_W-1:0] sig_in [2];

   assign exp_in[0] = bus.exp1;
   assign exp_in[1] = bus.exp2;
   assign sig_in[0] = bus.sig1;
   assign sig_in[1] = bus.sig2;

   logic out_valid_reg;

   always_ff @(posedge clk) begin
      if (reset) out_valid_reg <= 1'b0;
      else       out_valid_reg <= bus.in_valid;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_op
         logic             exp_zero, exp_ones, sig_zero;
         logic [EXP_W-1:0] exp_d_next;
         logic [EXP_W-1:0] exp_d_reg;
         logic             hidden_reg, zero_reg, denorm_reg, inf_reg, nan_reg;

         assign exp_zero = (exp_in[gi] == '0);
         assign exp_ones = (exp_in[gi] == {EXP_W{1'b1}});
         assign sig_zero = (sig_in[gi] == '0);

         // Subnormals share the scale of exponent 1, so alignment sees them uniformly.
         assign exp_d_next = exp_zero ? (sig_zero ? '0 : EXP_W'(1)) : exp_in[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               exp_d_reg  <= '0;
               hidden_reg <= 1'b0;
               zero_reg   <= 1'b0;
               denorm_reg <= 1'b0;
               inf_reg    <= 1'b0;
               nan_reg    <= 1'b0;
            end else begin
               exp_d_reg  <= exp_d_next;
               hidden_reg <= ~exp_zero;
               zero_reg   <= exp_zero & sig_zero;
               denorm_reg <= exp_zero & ~sig_zero;
               inf_reg    <= exp_ones & sig_zero;
               nan_reg    <= exp_ones & ~sig_zero;
            end
         end
      end
   endgenerate

   assign bus.out_valid = out_valid_reg;
   assign bus.exp1_d    = g_op[0].exp_d_reg;
   assign bus.exp2_d    = g_op[1].exp_d_reg;
   assign bus.n_concat  = {g_op[0].hidden_reg, g_op[1].hidden_reg};
   assign bus.zero1     = g_op[0].zero_reg;
   assign bus.denorm1   = g_op[0].denorm_reg;
   assign bus.inf1      = g_op[0].inf_reg;
   assign bus.nan1      = g_op[0].nan_reg;
   assign bus.zero2     = g_op[1].zero_reg;
   assign bus.denorm2   = g_op[1].denorm_reg;
   assign bus.inf2      = g_op[1].inf_reg;
   assign bus.nan2      = g_op[1].nan_reg;
endmodule

// File: tb/tb_denorm_zero.sv
// Scoreboard bench for denorm_zero: driver pushes expected results from an
// IEEE-754 classification model, a monitor pops and compares each cycle.
module tb_denorm_zero;
   localparam int EXP_W = 8;
   localparam int SIG_W = 23;

   typedef struct packed {
      logic             valid;
      logic [EXP_W-1:0] e1;
      logic [EXP_W-1:0] e2;
      logic [1:0]       hid;
      logic [7:0]       flags;   // zero1,denorm1,inf1,nan1,zero2,denorm2,inf2,nan2
   } result_t;

   typedef struct packed {
      logic [EXP_W-1:0] e;
      logic             h;
      logic [3:0]       f;       // zero,denorm,inf,nan
   } op_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   result_t exp_q[$];

   denorm_zero_if #(.EXP_W(EXP_W), .SIG_W(SIG_W)) bus ();

   denorm_zero #(.EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic op_t classify(input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] s);
      op_t r;
      int  ev;
      ev = int'(e);
      r  = '0;
      if (ev == 0 && s == 0) begin
         r.e = 0; r.h = 0; r.f = 4'b1000;
      end else if (ev == 0) begin
         r.e = 1; r.h = 0; r.f = 4'b0100;
      end else begin
         r.e = e; r.h = 1;
         if (ev == 2**EXP_W - 1) r.f = (s == 0) ? 4'b0010 : 4'b0001;
      end
      return r;
   endfunction

   function automatic result_t model(input logic rst, input logic v,
                                     input logic [EXP_W-1:0] e1, input logic [SIG_W-1:0] s1,
                                     input logic [EXP_W-1:0] e2, input logic [SIG_W-1:0] s2);
      result_t r;
      op_t     a, b;
      r = '0;
      if (!rst) begin
         a = classify(e1, s1);
         b = classify(e2, s2);
         r.valid = v;
         r.e1    = a.e;
         r.e2    = b.e;
         r.hid   = {a.h, b.h};
         r.flags = {a.f, b.f};
      end
      return r;
   endfunction

   task automatic drive(input logic rst, input logic v,
                        input logic [EXP_W-1:0] e1, input logic [SIG_W-1:0] s1,
                        input logic [EXP_W-1:0] e2, input logic [SIG_W-1:0] s2);
      @(negedge clk);
      reset        = rst;
      bus.in_valid = v;
      bus.exp1     = e1;
      bus.sig1     = s1;
      bus.exp2     = e2;
      bus.sig2     = s2;
      @(posedge clk);
      exp_q.push_back(model(rst, v, e1, s1, e2, s2));
   endtask

   function automatic logic [EXP_W-1:0] rand_exp();
      int r;
      r = int'($urandom_range(0, 5));
      if (r < 2)  return '0;
      if (r == 2) return '1;
      return EXP_W'($urandom_range(1, 2**EXP_W - 1));
   endfunction

   function automatic logic [SIG_W-1:0] rand_sig();
      if ($urandom_range(0, 1) == 0) return '0;
      return SIG_W'($urandom);
   endfunction

   // Monitor: one scoreboard entry per clock after its sampling edge.
   initial begin
      result_t act, expv;
      int      txn;
      txn = 0;
      forever begin
         @(negedge clk);
         act = {bus.out_valid, bus.exp1_d, bus.exp2_d, bus.n_concat,
                bus.zero1, bus.denorm1, bus.inf1, bus.nan1,
                bus.zero2, bus.denorm2, bus.inf2, bus.nan2};
         if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            tests++;
            txn++;
            if (act !== expv) begin
               fails++;
               $display("FAIL txn%0d result: got %h required %h", txn, act, expv);
            end else begin
               $display("[TB] txn %0d ok: %h", txn, act);
            end
         end else if (bus.out_valid === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: got 1 required no output");
         end
      end
   end

   initial begin
      int bound;
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.exp1     = '0;
      bus.sig1     = '0;
      bus.exp2     = '0;
      bus.sig2     = '0;

      repeat (2) drive(1'b1, 1'b1, rand_exp(), rand_sig(), rand_exp(), rand_sig());

      drive(1'b0, 1'b1, 8'h80, 23'h12345,  8'h01, 23'h0);
      drive(1'b0, 1'b1, 8'h00, 23'h000001, 8'h00, 23'h7FFFFF);
      drive(1'b0, 1'b1, 8'h00, 23'h0,      8'h7F, 23'h0);
      drive(1'b0, 1'b1, 8'hFF, 23'h0,      8'hFF, 23'h400000);

      for (int i = 0; i < 1000; i++) begin
         drive((i == 500) || (i == 501), ($urandom_range(0, 3) != 0),
               rand_exp(), rand_sig(), rand_exp(), rand_sig());
      end
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      bound = 0;
      while (exp_q.size() > 0 && bound < 10) begin
         @(posedge clk);
         bound++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
